// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: FSM states, opcodes,
// ALU operation codes, datapath mux selects and error codes.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    EXEC_I   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // States that wait on mem_ready and are therefore guarded by the timer.
  function automatic logic is_mem_wait_state(input state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for memory; reached flags the LIMIT-th
// consecutive wait cycle so the FSM can bail out on that same cycle.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic reached
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count_reg;

  // count_reg holds the number of wait cycles already completed, so the
  // current cycle is wait number count_reg+1.
  assign reached = enable && (count_reg == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !reached) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM with memory-wait timeout, illegal-opcode
// detection and a sticky HALT state left only through reset.
module multi_cycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic [1:0] err_code,
  output logic [3:0] state_o
);

  state_e     state_reg, state_next;
  logic [1:0] err_reg, err_next;
  logic       timer_clear, timer_enable, timeout_hit;

  // The branch outcome is resolved in the datapath via pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  assign timer_enable = is_mem_wait_state(state_reg) && !mem_ready;
  assign timer_clear  = (state_next != state_reg);

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .reached(timeout_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      err_reg   <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    err_next      = err_reg;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    halted        = 1'b0;

    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        // A late mem_ready on the timeout cycle still wins.
        if (mem_ready) begin
          state_next = DECODE;
        end else if (timeout_hit) begin
          state_next = HALT;
          err_next   = ERR_TIMEOUT;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:     state_next = EXEC_R;
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_ADDI:      state_next = EXEC_I;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          default: begin
            state_next = HALT;
            err_next   = ERR_ILLEGAL;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_next = MEM_WB;
        end else if (timeout_hit) begin
          state_next = HALT;
          err_next   = ERR_TIMEOUT;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_next = FETCH;
        end else if (timeout_hit) begin
          state_next = HALT;
          err_next   = ERR_TIMEOUT;
        end
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_RTYPE;
        state_next = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = FETCH;
      end
      EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_next    = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        state_next = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign err_code = err_reg;
  assign state_o  = state_reg;

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning max cycles spent waiting for mem_ready in one memory state.
REQ-002 The block SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion strobe.
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 B reg, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  out  3  000 add, 001 sub, 010 R-type (funct-decoded by ALUctrl).
- pc_source  out  2  00 ALU result, 01 ALUOut reg, 10 jump target.
- halted  out  1  sticky halt indication.
- err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- state_o  out  4  current state encoding, debug.

Function
REQ-003 The FSM SHALL have states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT.
REQ-004 Outputs SHALL be decoded from the current state; all controls not listed for a state SHALL be 0.
REQ-005 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; ir_write and pc_write SHALL equal mem_ready; advance to DECODE on mem_ready, else hold.
REQ-006 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000; next state by opcode: 000000->EXEC_R, 100011 or 101011->MEM_ADDR, 001000->EXEC_I, 000100->BRANCH, 000010->JUMP, any other->HALT with err_code=01.
REQ-007 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; next MEM_RD for 100011, MEM_WR for 101011.
REQ-008 MEM_RD: mem_read=1, iord=1; on mem_ready -> MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
REQ-009 MEM_WR: mem_write=1, iord=1; on mem_ready -> FETCH.
REQ-010 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010; -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
REQ-011 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=000; -> I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
REQ-012 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01; -> FETCH regardless of zero.
REQ-013 JUMP: pc_write=1, pc_source=10; -> FETCH.
REQ-014 With mem_ready held high, instruction latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-015 A wait counter SHALL clear on entry to FETCH, MEM_RD, MEM_WR and increment each cycle in that state without mem_ready.
REQ-016 When the counter reaches MEM_TIMEOUT with mem_ready low, the FSM SHALL enter HALT with err_code=10; mem_ready on that same cycle SHALL take priority (normal advance, no error).
REQ-017 HALT: all controls 0, halted=1, err_code held; HALT SHALL exit only via reset.
REQ-018 mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.

Reset
REQ-019 rst_n low SHALL immediately force state FETCH, wait counter 0, halted 0, err_code 00, regardless of current state including mid-memory-wait.
REQ-020 The first FETCH after rst_n rises SHALL behave as any FETCH (mem_read=1 from the first cycle).

Structure
REQ-021 State encodings, opcode constants, alu_op and err_code encodings SHALL live in shared package cpu_ctrl_pkg.
REQ-022 The wait counter SHALL be sub-module mem_wait_timer (clear, enable, count-reached output).

Verification
REQ-023 opcode=000000, mem_ready=1 -> states FETCH,DECODE,EXEC_R,R_WB, reg_write=1 reg_dst=1 in cycle 4, back to FETCH cycle 5.
REQ-024 opcode=100011, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, MEM_WB asserts reg_write=1 mem_to_reg=1, total 8 cycles.
REQ-025 opcode=000100, zero=1 -> BRANCH shows pc_write_cond=1 pc_source=01 alu_op=001; next state FETCH.
REQ-026 opcode=111111 -> DECODE->HALT, halted=1, err_code=01, persists 20 cycles until rst_n low.
REQ-027 MEM_TIMEOUT=15, mem_ready low in FETCH -> HALT after 15 wait cycles, err_code=10; variant with mem_ready high on cycle 15 -> DECODE, err_code=00.
REQ-028 rst_n asserted mid-MEM_WR -> same-cycle return to FETCH, all outputs at reset values, mem_write=0.
